// File: rtl/wb_slave_responder.sv
// Wishbone classic slave backed by a byte-lane-writable word memory with a fixed response latency.
// Optional macro WB_RESP_ERR_EN: out-of-range addresses terminate with err instead of aliasing.
module wb_slave_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_wb_adr,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_dat,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_dat,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_adr,
    input  logic [31:0]       bd_dat,
    output logic [15:0]       o_txn_count
);

    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          wait_cnt_reg, wait_cnt_next;
    logic [ADDR_W-1:0]   idx_reg;
    logic [3:0]          sel_reg;
    logic                we_reg;
    logic [31:0]         dat_reg;
    logic                err_reg;
    logic [31:0]         rd_data_reg;
    logic [15:0]         txn_count_reg;
    logic [31:0]         mem [DEPTH];

    logic                req;
    logic                req_err;
    logic [ADDR_W-1:0]   req_idx;
    logic [ADDR_W-1:0]   rd_idx;
    logic                resp;
    logic                bus_wr;
    logic [3:0]          lane_we;
    logic                unused_adr_bits;

    assign req     = i_wb_cyc & i_wb_stb;
    assign req_idx = i_wb_adr[ADDR_W+1:2];

`ifdef WB_RESP_ERR_EN
    assign req_err         = |i_wb_adr[31:ADDR_W+2];
    assign unused_adr_bits = &{1'b0, i_wb_adr[1:0]};
`else
    assign req_err         = 1'b0;
    assign unused_adr_bits = &{1'b0, i_wb_adr[31:ADDR_W+2], i_wb_adr[1:0]};
`endif

    // State and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                // Master withdrawing cyc abandons the transfer silently.
                if (!i_wb_cyc) begin
                    state_next    = IDLE;
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // Request capture; these registers only matter while a transfer is in flight.
    always_ff @(posedge clk) begin
        if (state_reg == IDLE && req) begin
            idx_reg <= req_idx;
            sel_reg <= i_wb_sel;
            we_reg  <= i_wb_we;
            dat_reg <= i_wb_dat;
            err_reg <= req_err;
        end
    end

    assign resp     = (state_reg == RESP);
    assign o_wb_ack = resp & ~err_reg;
    assign o_wb_err = resp & err_reg;
    assign o_wb_dat = (resp && !we_reg && !err_reg) ? rd_data_reg : 32'd0;

    // A reset arriving during RESP must still suppress the commit.
    assign bus_wr = resp & we_reg & ~err_reg & ~rst;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_we[gi] = bus_wr & sel_reg[gi];
    end

    // Read address follows the live request in IDLE so data is ready in the first RESP cycle.
    assign rd_idx = (state_reg == IDLE) ? req_idx : idx_reg;

    // Bus lanes are assigned after the backdoor so they take precedence on a collision.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_adr] <= bd_dat;
        end
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[idx_reg][8*b +: 8] <= dat_reg[8*b +: 8];
            end
        end
        rd_data_reg <= mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_count_reg <= 16'd0;
        end else if (o_wb_ack && txn_count_reg != 16'hFFFF) begin
            txn_count_reg <= txn_count_reg + 16'd1;
        end
    end

    assign o_txn_count = txn_count_reg;

endmodule

// File: tb/tb_wb_slave_responder.sv
// Bench for wb_slave_responder: two instances (WAIT_CYCLES 0 and 3) checked against a word-array model.
// Expectations follow WB_RESP_ERR_EN when the bench is compiled with that macro.
module tb_wb_slave_responder;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic [31:0] adr    [2];
    logic [3:0]  sel    [2];
    logic        we     [2];
    logic [31:0] wdat   [2];
    logic        cyc    [2];
    logic        stb    [2];
    logic        bd_we  [2];
    logic [AW-1:0] bd_adr [2];
    logic [31:0] bd_dat [2];
    logic [31:0] rdat   [2];
    logic        ack    [2];
    logic        err    [2];
    logic [15:0] cnt    [2];

    logic [31:0] mdl_mem [2][256];
    int          mdl_cnt [2];

    int checks   = 0;
    int failures = 0;

    wb_slave_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst[0]),
        .i_wb_adr(adr[0]), .i_wb_sel(sel[0]), .i_wb_we(we[0]), .i_wb_dat(wdat[0]),
        .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]),
        .o_wb_dat(rdat[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]),
        .bd_we(bd_we[0]), .bd_adr(bd_adr[0]), .bd_dat(bd_dat[0]),
        .o_txn_count(cnt[0])
    );

    wb_slave_responder #(.ADDR_W(AW), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst[1]),
        .i_wb_adr(adr[1]), .i_wb_sel(sel[1]), .i_wb_we(we[1]), .i_wb_dat(wdat[1]),
        .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]),
        .o_wb_dat(rdat[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]),
        .bd_we(bd_we[1]), .bd_adr(bd_adr[1]), .bd_dat(bd_dat[1]),
        .o_txn_count(cnt[1])
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic model_err(input logic [31:0] a);
`ifdef WB_RESP_ERR_EN
        return a[31:AW+2] != '0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    // Reference behaviour: word-addressed array, lane-masked writes, count of acks.
    task automatic model_apply(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] wd, output logic exp_err, output logic [31:0] exp_rd);
        int idx;
        idx     = int'(a[AW+1:2]);
        exp_err = model_err(a);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_rd = mdl_mem[d][idx];
            end
            if (mdl_cnt[d] < 65535) mdl_cnt[d]++;
        end
    endtask

    task automatic drive_idle(input int d);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        adr[d] = 32'd0; sel[d] = 4'd0; wdat[d] = 32'd0;
    endtask

    task automatic bd_write(input int d, input int a, input logic [31:0] v);
        @(negedge clk);
        bd_we[d] = 1'b1; bd_adr[d] = AW'(a); bd_dat[d] = v;
        @(negedge clk);
        bd_we[d] = 1'b0;
        mdl_mem[d][a] = v;
    endtask

    task automatic run_xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] wd, output logic [31:0] got_rd, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        got_ack, idle_bad, both;
        int          lat;
        model_apply(d, w, a, s, wd, exp_err, exp_rd);
        @(negedge clk);
        adr[d] = a; sel[d] = s; we[d] = w; wdat[d] = wd; cyc[d] = 1'b1; stb[d] = 1'b1;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; got_rd = 32'd0; idle_bad = 1'b0; both = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) stb[d] = 1'b0;
            if (ack[d] && err[d]) both = 1'b1;
            if (ack[d] || err[d]) begin
                got_ack = ack[d]; got_err = err[d]; got_rd = rdat[d]; lat = i;
                break;
            end else if (rdat[d] != 32'd0) begin
                idle_bad = 1'b1;
            end
        end
        cyc[d] = 1'b0;
        @(negedge clk);
        if (ack[d] || err[d] || rdat[d] != 32'd0) idle_bad = 1'b1;
        $display("txn dut=%0d we=%0b adr=%08h sel=%04b wdat=%08h ack=%0b err=%0b rdat=%08h lat=%0d cnt=%0d",
                 d, w, a, s, wd, got_ack, got_err, got_rd, lat, cnt[d]);
        chk("latency", 32'(lat), 32'(wait_of(d) + 1));
        chk("ack", 32'(got_ack), 32'(!exp_err));
        chk("err", 32'(got_err), 32'(exp_err));
        chk("rdata", got_rd, exp_rd);
        chk("ack_err_exclusive", 32'(both), 32'd0);
        chk("quiet_outside_resp", 32'(idle_bad), 32'd0);
        chk("txn_count", 32'(cnt[d]), 32'(mdl_cnt[d]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got_rd, old;
        logic        got_err, bad;
        logic [5:0]  pat;
        logic [15:0] cnt_before;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; bd_we[d] = 1'b0; bd_adr[d] = '0; bd_dat[d] = '0;
            drive_idle(d);
            mdl_cnt[d] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack", 32'(ack[d]), 32'd0);
            chk("reset_err", 32'(err[d]), 32'd0);
            chk("reset_dat", rdat[d], 32'd0);
            chk("reset_count", 32'(cnt[d]), 32'd0);
        end

        // Fill both memories with random words through the backdoor
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                bd_we[d] = 1'b1; bd_adr[d] = AW'(i); bd_dat[d] = $urandom;
                mdl_mem[d][i] = bd_dat[d];
            end
        end
        @(negedge clk);
        bd_we[0] = 1'b0; bd_we[1] = 1'b0;

        bd_write(0, 3, 32'hE3A01005);
        bd_write(0, 0, 32'h11223344);
        bd_write(0, 7, 32'h00000000);

        vecs[0]  = '{1'b0, 32'h0000000C, 4'b1111, 32'h0,        1'b0, 32'hE3A01005};
        vecs[1]  = '{1'b1, 32'h00000000, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h00000000, 4'b0000, 32'h0,        1'b0, 32'h11BB33DD};
        vecs[3]  = '{1'b0, 32'h00000003, 4'b0001, 32'h0,        1'b0, 32'h11BB33DD};
        vecs[4]  = '{1'b1, 32'h0000001C, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000001C, 4'b1111, 32'h0,        1'b0, 32'h00000000};
        vecs[6]  = '{1'b1, 32'h0000001C, 4'b1111, 32'h12345678, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000001E, 4'b1111, 32'h0,        1'b0, 32'h12345678};
        vecs[8]  = '{1'b1, 32'h0000001C, 4'b1000, 32'hAB000000, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000001C, 4'b1111, 32'h0,        1'b0, 32'hAB345678};
`ifdef WB_RESP_ERR_EN
        vecs[10] = '{1'b1, 32'h00000400, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h00000000, 4'b1111, 32'h0,        1'b0, 32'h11BB33DD};
`else
        vecs[10] = '{1'b1, 32'h00000400, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h00000000, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF};
`endif

        for (int v = 0; v < 12; v++) begin
            run_xfer(0, vecs[v].we, vecs[v].adr, vecs[v].sel, vecs[v].dat, got_rd, got_err);
            chk($sformatf("vec%0d_rdata", v), got_rd, vecs[v].exp_rd);
            chk($sformatf("vec%0d_err", v), 32'(got_err), 32'(vecs[v].exp_err));
        end
        chk("count_after_table", 32'(cnt[0]), 32'(vecs[10].exp_err ? 11 : 12));

        // Back-to-back reads with stb held: acks must be spaced by an idle cycle
        @(negedge clk);
        adr[0] = 32'h0000000C; we[0] = 1'b0; sel[0] = 4'b1111; cyc[0] = 1'b1; stb[0] = 1'b1;
        pat = 6'd0; bad = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            pat[i-1] = ack[0];
            if (ack[0] && rdat[0] != 32'hE3A01005) bad = 1'b1;
            if (i == 5) begin cyc[0] = 1'b0; stb[0] = 1'b0; end
        end
        mdl_cnt[0] += 3;
        @(negedge clk);
        $display("txn dut=0 back_to_back ack_pattern=%06b cnt=%0d", pat, cnt[0]);
        chk("b2b_ack_pattern", 32'(pat), 32'(6'b010101));
        chk("b2b_rdata", 32'(bad), 32'd0);
        chk("b2b_count", 32'(cnt[0]), 32'(mdl_cnt[0]));

        // Wait-state read: ack only after three wait cycles
        run_xfer(1, 1'b0, 32'h0000000C, 4'b1111, 32'h0, got_rd, got_err);

        // Abort: cyc dropped in the second wait cycle of a write
        cnt_before = cnt[1];
        @(negedge clk);
        adr[1] = 32'h00000024; we[1] = 1'b1; sel[1] = 4'b1111; wdat[1] = 32'h0BADC0DE;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(negedge clk); stb[1] = 1'b0;
        @(negedge clk); cyc[1] = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack[1] || err[1]) bad = 1'b1;
        end
        drive_idle(1);
        $display("txn dut=1 aborted write adr=00000024 resp_seen=%0b cnt=%0d", bad, cnt[1]);
        chk("abort_no_resp", 32'(bad), 32'd0);
        chk("abort_count", 32'(cnt[1]), 32'(cnt_before));
        run_xfer(1, 1'b0, 32'h00000024, 4'b1111, 32'h0, got_rd, got_err);

        // Reset in the middle of a write's wait cycles
        old = mdl_mem[1][5];
        @(negedge clk);
        adr[1] = 32'h00000014; we[1] = 1'b1; sel[1] = 4'b1111; wdat[1] = 32'hCAFEF00D;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(negedge clk); stb[1] = 1'b0;
        @(negedge clk); rst[1] = 1'b1;
        @(negedge clk); rst[1] = 1'b0; drive_idle(1);
        mdl_cnt[1] = 0;
        $display("txn dut=1 reset during write wait ack=%0b err=%0b cnt=%0d", ack[1], err[1], cnt[1]);
        chk("rst_wait_ack", 32'(ack[1]), 32'd0);
        chk("rst_wait_err", 32'(err[1]), 32'd0);
        chk("rst_wait_count", 32'(cnt[1]), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack[1] || err[1]) bad = 1'b1;
        end
        chk("rst_wait_no_late_resp", 32'(bad), 32'd0);
        run_xfer(1, 1'b0, 32'h00000014, 4'b1111, 32'h0, got_rd, got_err);
        chk("rst_wait_word5", got_rd, old);

        // Randomised traffic against the model
        for (int n = 0; n < 150; n++) begin
            for (int d = 0; d < 2; d++) begin
                logic        w;
                logic [31:0] a;
                logic [21:0] up;
                w  = 1'($urandom_range(0, 1));
                up = ($urandom_range(0, 3) == 0) ? 22'($urandom) : 22'd0;
                a  = {up, 8'($urandom_range(0, 15)), 2'($urandom)};
                run_xfer(d, w, a, 4'($urandom), $urandom, got_rd, got_err);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
